// File: rtl/operand_pair_loader.sv
// rtl/operand_pair_loader.sv - byte-stream to operand-pair FIFO feeder for the 8-bit adder stage (optional PAIR_COUNT_EN)
module operand_pair_loader #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          op_a,
   output logic [DATA_W-1:0]          op_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       pending_a
`ifdef PAIR_COUNT_EN
   ,
   output logic [7:0]                 pair_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {WAIT_A = 1'b0, WAIT_B = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       a_hold;
   logic [2*DATA_W-1:0]     mem [DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [2*DATA_W-1:0]     head;
   logic                    push, pop, accept;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;
   assign head   = mem[rd_ptr];

   // Pairing FSM: next state, input handshake and FIFO push decision
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b1;
      push      = 1'b0;
      pending_a = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (in_valid) state_d = WAIT_B;
         end
         WAIT_B: begin
            pending_a = 1'b1;
            // Only the registered level gates B, so in_ready never sees out_ready.
            in_ready  = (level < LW'(DEPTH));
            if (in_valid && in_ready) begin
               push    = 1'b1;
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // FSM state register and held A byte
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= WAIT_A;
         a_hold  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT_A && accept) a_hold <= in_data;
      end
   end

   // Pair storage; content is qualified by level so it needs no reset
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) mem[wr_ptr] <= {a_hold, in_data};
   end

   // Pointers and occupancy; flush discards any push or pop in the same cycle
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Head presentation, zeroed while the FIFO is empty
   always_comb begin
      out_valid = (level != '0);
      op_a      = out_valid ? head[2*DATA_W-1:DATA_W] : '0;
      op_b      = out_valid ? head[DATA_W-1:0]        : '0;
   end

`ifdef PAIR_COUNT_EN
   // Saturating count of consumed pairs
   always_ff @(posedge clk) begin
      if (rst || flush)                pair_count <= '0;
      else if (pop && pair_count != 8'hFF) pair_count <= pair_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_operand_pair_loader.sv
// tb/tb_operand_pair_loader.sv - scoreboard bench for operand_pair_loader
module tb_operand_pair_loader;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready, pending_a;
   logic [DATA_W-1:0] in_data, op_a, op_b;
   logic [LW-1:0]     level;
`ifdef PAIR_COUNT_EN
   logic [7:0]        pair_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0]       exp_q[$];
   logic              have_a;
   logic [7:0]        a_byte;

   operand_pair_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .pending_a(pending_a)
`ifdef PAIR_COUNT_EN
      , .pair_count(pair_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: compare every pop against the queued pair
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", {op_a, op_b}, 32'hFFFF_FFFF);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("pop_op_a", op_a, e[15:8]);
            check("pop_op_b", op_b, e[7:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and hold it until accepted; inputs change just after an edge
   task automatic drive_byte(input logic [7:0] b);
      bit done = 0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            if (!have_a) begin
               a_byte = b;
               have_a = 1'b1;
            end else begin
               exp_q.push_back({a_byte, b});
               have_a = 1'b0;
            end
         end
         step();
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      have_a = 1'b0;
   endtask

   task automatic do_flush();
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      clear_model();
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (exp_q.size() == 0 && level == 0) done = 1;
         else step();
      end
      check("drain", done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      clear_model();
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_level", level, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_op", {op_a, op_b}, 0);
      check("rst_pending_a", pending_a, 0);
      check("rst_in_ready", in_ready, 1);

      // Single pair with one-cycle latency
      out_ready = 1'b1;
      drive_byte(8'h12);
      check("pending_after_a", pending_a, 1);
      check("no_out_after_a", out_valid, 0);
      drive_byte(8'h34);
      idle();
      check("latency_out_valid", out_valid, 1);
      check("latency_level", level, 1);
      step();
      check("after_pop_level", level, 0);
      check("after_pop_op_zero", {op_a, op_b}, 0);

      // Back-pressure: fill, stall, then release in order
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) drive_byte(8'(i));
      check("full_level", level, 4);
      drive_byte(8'h09);
      check("full_pending_a", pending_a, 1);
      in_data = 8'h0A; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_op_a_stable", op_a, 8'h01);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("full_pop_refuses_b", in_ready, 0);
      step();
      drive_byte(8'h0A);
      idle();
      wait_drain();

      // Flush discards a pending A byte
      drive_byte(8'hAA);
      idle();
      check("flush_pre_pending", pending_a, 1);
      do_flush();
      check("flush_pending_a", pending_a, 0);
      check("flush_level", level, 0);
      drive_byte(8'h05);
      drive_byte(8'h06);
      idle();
      wait_drain();

      // Reset with three pairs buffered
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) drive_byte(8'($urandom_range(0, 255)));
      idle();
      check("pre_rst_level", level, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_model();
      check("mid_rst_level", level, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_op", {op_a, op_b}, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_pending_a", pending_a, 0);

      // Random stream with random back-pressure
      for (int i = 0; i < 40; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         drive_byte(8'($urandom_range(0, 255)));
      end
      idle();
      out_ready = 1'b1;
      wait_drain();

`ifdef PAIR_COUNT_EN
      do_flush();
      check("cnt_after_flush0", pair_count, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) drive_byte(8'(i));
      idle();
      wait_drain();
      check("cnt_ten", pair_count, 10);
      for (int i = 0; i < 580; i++) drive_byte(8'(i));
      idle();
      wait_drain();
      check("cnt_saturate", pair_count, 255);
      do_flush();
      check("cnt_after_flush", pair_count, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
